// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Selects the next PC, reads the instruction ROM and registers the word for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jmp_taken,
  input  logic [31:0]            jmp_target,
  input  logic                   jr_taken,
  input  logic [31:0]            jr_target,
  input  logic                   halt,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_data,
  output logic [31:0]            pc,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_pc4,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
  output logic [5:0]             op,
  output logic [5:0]             func,
  output logic                   halted,
  output logic [31:0]            fetch_count
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirects and halt squash the word fetched this cycle by loading a bubble.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    if (state_q == RUN) begin
      if (halt) begin
        state_d       = HALTED;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end else if (branch_taken) begin
        pc_d          = branch_target & ALIGN_MASK;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (jr_taken) begin
        pc_d          = jr_target & ALIGN_MASK;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end else if (jmp_taken) begin
        pc_d          = jmp_target & ALIGN_MASK;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end else begin
        pc_d          = pc_plus4;
        if_id_pc_d    = pc_q;
        if_id_pc4_d   = pc_plus4;
        if_id_instr_d = imem_data;
        if_id_valid_d = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC & ALIGN_MASK;
      if_id_pc_q    <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // The ROM aliases: upper PC bits are simply dropped from the word address.
  assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign op          = if_id_instr_q[31:26];
  assign func        = if_id_instr_q[5:0];
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized control inputs,
// compared against a behavioural fetch model; a second instance covers a wrapping reset PC.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jmp_taken, jr_taken, halt;
  logic [31:0] branch_target, jmp_target, jr_target;

  logic [9:0]  imem_addr_a, imem_addr_b;
  logic [31:0] imem_data_a, imem_data_b;
  logic [31:0] pc_a, if_id_pc_a, if_id_pc4_a, if_id_instr_a, fetch_count_a;
  logic [31:0] pc_b, if_id_pc_b, if_id_pc4_b, if_id_instr_b, fetch_count_b;
  logic [5:0]  op_a, func_a, op_b, func_b;
  logic        if_id_valid_a, halted_a, if_id_valid_b, halted_b;

  logic [31:0] rom [0:1023];

  logic [31:0] m_reset_pc [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_ipc [2];
  logic [31:0] m_ipc4 [2];
  logic [31:0] m_instr [2];
  logic        m_valid [2];
  logic        m_halted [2];
  logic [31:0] m_count [2];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign imem_data_a = rom[imem_addr_a];
  assign imem_data_b = rom[imem_addr_b];

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10), .NOP_INSTR(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jmp_taken(jmp_taken), .jmp_target(jmp_target),
    .jr_taken(jr_taken), .jr_target(jr_target), .halt(halt),
    .imem_addr(imem_addr_a), .imem_data(imem_data_a), .pc(pc_a),
    .if_id_pc(if_id_pc_a), .if_id_pc4(if_id_pc4_a), .if_id_instr(if_id_instr_a),
    .if_id_valid(if_id_valid_a), .op(op_a), .func(func_a),
    .halted(halted_a), .fetch_count(fetch_count_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_ADDR_W(10), .NOP_INSTR(32'h0000_0000)) dut_b (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jmp_taken(jmp_taken), .jmp_target(jmp_target),
    .jr_taken(jr_taken), .jr_target(jr_target), .halt(halt),
    .imem_addr(imem_addr_b), .imem_data(imem_data_b), .pc(pc_b),
    .if_id_pc(if_id_pc_b), .if_id_pc4(if_id_pc4_b), .if_id_instr(if_id_instr_b),
    .if_id_valid(if_id_valid_b), .op(op_b), .func(func_b),
    .halted(halted_b), .fetch_count(fetch_count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Behavioural fetch model: one call = one rising edge with the current inputs.
  function automatic void modelStep();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] word_index;
      if (rst) begin
        m_pc[k] = m_reset_pc[k] & 32'hFFFF_FFFC;
        m_ipc[k] = 0; m_ipc4[k] = 0; m_instr[k] = 0;
        m_valid[k] = 0; m_halted[k] = 0; m_count[k] = 0;
      end else if (m_halted[k]) begin
        // frozen until reset
      end else if (halt) begin
        m_halted[k] = 1; m_instr[k] = 0; m_valid[k] = 0;
      end else if (branch_taken) begin
        m_pc[k] = (branch_target / 4) * 4; m_instr[k] = 0; m_valid[k] = 0;
      end else if (stall) begin
        // hold everything
      end else if (jr_taken) begin
        m_pc[k] = (jr_target / 4) * 4; m_instr[k] = 0; m_valid[k] = 0;
      end else if (jmp_taken) begin
        m_pc[k] = (jmp_target / 4) * 4; m_instr[k] = 0; m_valid[k] = 0;
      end else begin
        word_index = (m_pc[k] / 4) % 1024;
        m_instr[k] = rom[word_index];
        m_ipc[k] = m_pc[k];
        m_ipc4[k] = m_pc[k] + 4;
        m_valid[k] = 1;
        m_count[k] = m_count[k] + 1;
        m_pc[k] = m_pc[k] + 4;
      end
    end
  endfunction

  task automatic checkDut(input string name, input int k,
                          input logic [31:0] pc_o, input logic [31:0] ipc_o, input logic [31:0] ipc4_o,
                          input logic [31:0] instr_o, input logic valid_o, input logic [5:0] op_o,
                          input logic [5:0] func_o, input logic halted_o, input logic [31:0] count_o,
                          input logic [9:0] addr_o);
    logic [31:0] exp_instr;
    exp_instr = m_instr[k];
    checkOutput({name, " pc"}, pc_o, m_pc[k]);
    checkOutput({name, " imem_addr"}, {22'd0, addr_o}, (m_pc[k] / 4) % 1024);
    checkOutput({name, " if_id_valid"}, {31'd0, valid_o}, {31'd0, m_valid[k]});
    checkOutput({name, " if_id_instr"}, instr_o, exp_instr);
    checkOutput({name, " op"}, {26'd0, op_o}, {26'd0, exp_instr[31:26]});
    checkOutput({name, " func"}, {26'd0, func_o}, {26'd0, exp_instr[5:0]});
    checkOutput({name, " halted"}, {31'd0, halted_o}, {31'd0, m_halted[k]});
    checkOutput({name, " fetch_count"}, count_o, m_count[k]);
    if (m_valid[k]) begin
      checkOutput({name, " if_id_pc"}, ipc_o, m_ipc[k]);
      checkOutput({name, " if_id_pc4"}, ipc4_o, m_ipc4[k]);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt, input logic j, input logic [31:0] jrt,
                               input logic h);
    rst = r; stall = s; branch_taken = b; branch_target = bt;
    jmp_taken = jp; jmp_target = jt; jr_taken = j; jr_target = jrt; halt = h;
    modelStep();
    @(posedge clk);
    #1;
    checkDut("A", 0, pc_a, if_id_pc_a, if_id_pc4_a, if_id_instr_a, if_id_valid_a, op_a, func_a,
             halted_a, fetch_count_a, imem_addr_a);
    checkDut("B", 1, pc_b, if_id_pc_b, if_id_pc4_b, if_id_instr_b, if_id_valid_b, op_b, func_b,
             halted_b, fetch_count_b, imem_addr_b);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset_pc[0] = 32'h0000_0000;
    m_reset_pc[1] = 32'hFFFF_FFFC;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_ipc[k] = 0; m_ipc4[k] = 0; m_instr[k] = 0;
      m_valid[k] = 0; m_halted[k] = 0; m_count[k] = 0;
    end
    for (int i = 0; i < 1024; i++) rom[i] = i + 1;

    // Reset and sequential fetch
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset pc", pc_a, 32'h0);
    checkOutput("reset valid", {31'd0, if_id_valid_a}, 32'd0);
    idle();
    checkOutput("first if_id_pc", if_id_pc_a, 32'h0);
    checkOutput("first if_id_instr", if_id_instr_a, 32'd1);
    checkOutput("first fetch_count", fetch_count_a, 32'd1);
    idle();
    checkOutput("seq pc", pc_a, 32'h8);

    // Stall holds PC and IF/ID
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall pc", pc_a, 32'h8);
    checkOutput("stall if_id_pc", if_id_pc_a, 32'h4);
    checkOutput("stall fetch_count", fetch_count_a, 32'd2);
    idle();
    checkOutput("unstall if_id_pc", if_id_pc_a, 32'h8);

    // Branch overrides stall, target alignment
    applyStimulus(0, 1, 1, 32'h43, 0, 0, 0, 0, 0);
    checkOutput("branch pc", pc_a, 32'h40);
    checkOutput("branch bubble", {31'd0, if_id_valid_a}, 32'd0);
    idle();
    checkOutput("branch if_id_pc", if_id_pc_a, 32'h40);
    checkOutput("branch if_id_instr", if_id_instr_a, 32'd17);

    // jr beats jmp
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 1, 32'h200, 0);
    checkOutput("jr pc", pc_a, 32'h200);
    checkOutput("jr bubble", {31'd0, if_id_valid_a}, 32'd0);
    idle();

    // Halt freezes fetch until reset
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("halt halted", {31'd0, halted_a}, 32'd1);
    checkOutput("halt pc", pc_a, 32'h10);
    applyStimulus(0, 0, 1, 32'h80, 1, 32'h300, 0, 0, 0);
    idle();
    checkOutput("halted pc frozen", pc_a, 32'h10);
    checkOutput("halted valid", {31'd0, if_id_valid_a}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post-halt reset pc", pc_a, 32'h0);
    checkOutput("post-halt halted", {31'd0, halted_a}, 32'd0);

    // Wrapping reset PC on instance B
    checkOutput("B reset pc", pc_b, 32'hFFFF_FFFC);
    idle();
    checkOutput("B wrap pc", pc_b, 32'h0);
    checkOutput("B wrap if_id_pc", if_id_pc_b, 32'hFFFF_FFFC);
    checkOutput("B wrap if_id_pc4", if_id_pc4_b, 32'h0);
    checkOutput("B wrap instr", if_id_instr_b, 32'd1024);

    // Randomized control traffic with random ROM contents
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] bt, jt, jrt;
      bt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      jt  = $urandom;
      jrt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, bt, $urandom_range(0, 7) == 0, jt,
                    $urandom_range(0, 7) == 0, jrt, $urandom_range(0, 79) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
